// File: rtl/ctrl_pkg.sv
// Shared encodings and the EX control bundle for the ID control stage.
package ctrl_pkg;

    localparam logic [6:0] OP_R      = 7'b0110011;
    localparam logic [6:0] OP_I      = 7'b0010011;
    localparam logic [6:0] OP_LOAD   = 7'b0000011;
    localparam logic [6:0] OP_STORE  = 7'b0100011;
    localparam logic [6:0] OP_BRANCH = 7'b1100011;
    localparam logic [6:0] OP_JAL    = 7'b1101111;
    localparam logic [6:0] OP_JALR   = 7'b1100111;

    localparam logic [1:0] ALU_R   = 2'b00;
    localparam logic [1:0] ALU_I   = 2'b01;
    localparam logic [1:0] ALU_MEM = 2'b10;
    localparam logic [1:0] ALU_JMP = 2'b11;

    localparam logic [6:0] FUNCT7_MULDIV = 7'b0000001;

    typedef enum logic {
        RUN     = 1'b0,
        MD_BUSY = 1'b1
    } state_e;

    typedef struct packed {
        logic       valid;
        logic       jalr;
        logic       jal;
        logic       branch;
        logic       memread;
        logic       memtoreg;
        logic       memwrite;
        logic       alusrc;
        logic       regwrite;
        logic       muldiv;
        logic       illegal;
        logic [1:0] aluop;
        logic [4:0] rd;
    } ctrl_t;

    localparam ctrl_t CTRL_BUBBLE = '0;

    function automatic int unsigned max_u(input int unsigned a, input int unsigned b);
        return (a > b) ? a : b;
    endfunction

endpackage

// File: rtl/ctrl_main_dec.sv
// Combinational main decoder: opcode/funct7 to EX control bundle and source-register usage.
module ctrl_main_dec
    import ctrl_pkg::*;
#(
    parameter bit EN_MULDIV = 1'b1
) (
    input  logic [6:0] opcode,
    input  logic [6:0] funct7,
    input  logic [4:0] rd,
    output ctrl_t      ctrl,
    output logic       rs1_used,
    output logic       rs2_used
);

    logic illegal;

    always_comb begin
        ctrl     = CTRL_BUBBLE;
        illegal  = 1'b0;
        rs1_used = (opcode != OP_JAL);
        rs2_used = 1'b0;
        ctrl.valid = 1'b1;
        ctrl.rd    = rd;
        unique case (opcode)
            OP_R: begin
                ctrl.regwrite = 1'b1;
                ctrl.aluop    = ALU_R;
                rs2_used      = 1'b1;
                if (funct7 == FUNCT7_MULDIV) begin
                    if (EN_MULDIV) ctrl.muldiv = 1'b1;
                    else           illegal     = 1'b1;
                end
            end
            OP_I: begin
                ctrl.alusrc   = 1'b1;
                ctrl.regwrite = 1'b1;
                ctrl.aluop    = ALU_I;
            end
            OP_LOAD: begin
                ctrl.memread  = 1'b1;
                ctrl.memtoreg = 1'b1;
                ctrl.alusrc   = 1'b1;
                ctrl.regwrite = 1'b1;
                ctrl.aluop    = ALU_MEM;
            end
            OP_STORE: begin
                ctrl.memwrite = 1'b1;
                ctrl.alusrc   = 1'b1;
                ctrl.aluop    = ALU_MEM;
                rs2_used      = 1'b1;
            end
            OP_BRANCH: begin
                ctrl.branch = 1'b1;
                ctrl.aluop  = ALU_R;
                rs2_used    = 1'b1;
            end
            OP_JAL: begin
                ctrl.jal      = 1'b1;
                ctrl.regwrite = 1'b1;
                ctrl.aluop    = ALU_JMP;
            end
            OP_JALR: begin
                ctrl.jalr     = 1'b1;
                ctrl.alusrc   = 1'b1;
                ctrl.regwrite = 1'b1;
                ctrl.aluop    = ALU_JMP;
            end
            default: illegal = 1'b1;
        endcase
        // Illegal encodings travel as a valid op with every control (and rd) cleared.
        if (illegal) begin
            ctrl         = CTRL_BUBBLE;
            ctrl.valid   = 1'b1;
            ctrl.illegal = 1'b1;
        end
    end

endmodule

// File: rtl/id_ctrl_stage.sv
// ID control stage: registers the decoded bundle into EX, detects load-use hazards
// and sequences multi-cycle MUL/DIV occupancy of EX.
module id_ctrl_stage
    import ctrl_pkg::*;
#(
    parameter bit          EN_MULDIV = 1'b1,
    parameter int unsigned MUL_LAT   = 3,
    parameter int unsigned DIV_LAT   = 32
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       dcache_stall,
    input  logic       ex_redirect,
    input  logic       id_valid,
    input  logic [6:0] id_opcode,
    input  logic [2:0] id_funct3,
    input  logic [6:0] id_funct7,
    input  logic [4:0] id_rs1,
    input  logic [4:0] id_rs2,
    input  logic [4:0] id_rd,
    output logic       ex_valid,
    output logic       ex_jalr,
    output logic       ex_jal,
    output logic       ex_branch,
    output logic       ex_memread,
    output logic       ex_memtoreg,
    output logic       ex_memwrite,
    output logic       ex_alusrc,
    output logic       ex_regwrite,
    output logic       ex_muldiv,
    output logic       ex_illegal,
    output logic [1:0] ex_aluop,
    output logic [4:0] ex_rd,
    output logic       ex_hold,
    output logic       if_id_stall,
    output logic       if_flush_req
);

    localparam int unsigned CNT_W = $clog2(max_u(MUL_LAT, DIV_LAT) + 1);
    localparam logic [CNT_W-1:0] MUL_INIT = CNT_W'(MUL_LAT - 1);
    localparam logic [CNT_W-1:0] DIV_INIT = CNT_W'(DIV_LAT - 1);

    ctrl_t            dec;
    logic             rs1_used;
    logic             rs2_used;
    logic             load_use;
    ctrl_t            ex_d, ex_q;
    state_e           state_d, state_q;
    logic [CNT_W-1:0] cnt_d, cnt_q;
    logic             unused_funct3;

    assign unused_funct3 = ^id_funct3[1:0];

    ctrl_main_dec #(
        .EN_MULDIV(EN_MULDIV)
    ) u_main_dec (
        .opcode   (id_opcode),
        .funct7   (id_funct7),
        .rd       (id_rd),
        .ctrl     (dec),
        .rs1_used (rs1_used),
        .rs2_used (rs2_used)
    );

    assign load_use = id_valid && ex_q.valid && ex_q.memread && (ex_q.rd != '0) &&
                      ((rs1_used && (ex_q.rd == id_rs1)) || (rs2_used && (ex_q.rd == id_rs2)));

    always_comb begin
        ex_d         = ex_q;
        state_d      = state_q;
        cnt_d        = cnt_q;
        if_id_stall  = 1'b0;
        if_flush_req = 1'b0;
        if (dcache_stall) begin
            if_id_stall = 1'b1;
        end else if (ex_redirect) begin
            ex_d    = CTRL_BUBBLE;
            state_d = RUN;
            cnt_d   = '0;
        end else if (state_q == MD_BUSY) begin
            cnt_d       = cnt_q - CNT_W'(1);
            if_id_stall = 1'b1;
            if (cnt_q == CNT_W'(1)) state_d = RUN;
        end else if (load_use) begin
            ex_d        = CTRL_BUBBLE;
            if_id_stall = 1'b1;
        end else if (id_valid) begin
            ex_d         = dec;
            if_flush_req = dec.jal || dec.jalr;
            // cnt holds the remaining hold cycles; a latency of 1 never leaves RUN.
            if (dec.muldiv) begin
                cnt_d = id_funct3[2] ? DIV_INIT : MUL_INIT;
                if (cnt_d != '0) state_d = MD_BUSY;
            end
        end else begin
            ex_d = CTRL_BUBBLE;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ex_q    <= CTRL_BUBBLE;
            state_q <= RUN;
            cnt_q   <= '0;
        end else begin
            ex_q    <= ex_d;
            state_q <= state_d;
            cnt_q   <= cnt_d;
        end
    end

    assign ex_valid    = ex_q.valid;
    assign ex_jalr     = ex_q.jalr;
    assign ex_jal      = ex_q.jal;
    assign ex_branch   = ex_q.branch;
    assign ex_memread  = ex_q.memread;
    assign ex_memtoreg = ex_q.memtoreg;
    assign ex_memwrite = ex_q.memwrite;
    assign ex_alusrc   = ex_q.alusrc;
    assign ex_regwrite = ex_q.regwrite;
    assign ex_muldiv   = ex_q.muldiv;
    assign ex_illegal  = ex_q.illegal;
    assign ex_aluop    = ex_q.aluop;
    assign ex_rd       = ex_q.rd;
    assign ex_hold     = (state_q == MD_BUSY);

endmodule

// File: tb/tb_id_ctrl_stage.sv
// Self-checking bench for id_ctrl_stage: decode table, directed hazard/muldiv
// sequences, and randomized traffic against an occupancy-level reference model.
module tb_id_ctrl_stage;

    localparam int MUL_LAT = 3;
    localparam int DIV_LAT = 32;

    logic       clk, rst_n, dcache_stall, ex_redirect, id_valid;
    logic [6:0] id_opcode, id_funct7;
    logic [2:0] id_funct3;
    logic [4:0] id_rs1, id_rs2, id_rd;

    logic       ex_valid, ex_jalr, ex_jal, ex_branch, ex_memread, ex_memtoreg, ex_memwrite;
    logic       ex_alusrc, ex_regwrite, ex_muldiv, ex_illegal, ex_hold, if_id_stall, if_flush_req;
    logic [1:0] ex_aluop;
    logic [4:0] ex_rd;

    logic       nm_valid, nm_jalr, nm_jal, nm_branch, nm_memread, nm_memtoreg, nm_memwrite;
    logic       nm_alusrc, nm_regwrite, nm_muldiv, nm_illegal, nm_hold, nm_stall, nm_flush;
    logic [1:0] nm_aluop;
    logic [4:0] nm_rd;

    id_ctrl_stage #(.EN_MULDIV(1'b1), .MUL_LAT(MUL_LAT), .DIV_LAT(DIV_LAT)) dut (
        .clk(clk), .rst_n(rst_n), .dcache_stall(dcache_stall), .ex_redirect(ex_redirect),
        .id_valid(id_valid), .id_opcode(id_opcode), .id_funct3(id_funct3), .id_funct7(id_funct7),
        .id_rs1(id_rs1), .id_rs2(id_rs2), .id_rd(id_rd),
        .ex_valid(ex_valid), .ex_jalr(ex_jalr), .ex_jal(ex_jal), .ex_branch(ex_branch),
        .ex_memread(ex_memread), .ex_memtoreg(ex_memtoreg), .ex_memwrite(ex_memwrite),
        .ex_alusrc(ex_alusrc), .ex_regwrite(ex_regwrite), .ex_muldiv(ex_muldiv),
        .ex_illegal(ex_illegal), .ex_aluop(ex_aluop), .ex_rd(ex_rd), .ex_hold(ex_hold),
        .if_id_stall(if_id_stall), .if_flush_req(if_flush_req)
    );

    id_ctrl_stage #(.EN_MULDIV(1'b0), .MUL_LAT(MUL_LAT), .DIV_LAT(DIV_LAT)) dut_nm (
        .clk(clk), .rst_n(rst_n), .dcache_stall(dcache_stall), .ex_redirect(ex_redirect),
        .id_valid(id_valid), .id_opcode(id_opcode), .id_funct3(id_funct3), .id_funct7(id_funct7),
        .id_rs1(id_rs1), .id_rs2(id_rs2), .id_rd(id_rd),
        .ex_valid(nm_valid), .ex_jalr(nm_jalr), .ex_jal(nm_jal), .ex_branch(nm_branch),
        .ex_memread(nm_memread), .ex_memtoreg(nm_memtoreg), .ex_memwrite(nm_memwrite),
        .ex_alusrc(nm_alusrc), .ex_regwrite(nm_regwrite), .ex_muldiv(nm_muldiv),
        .ex_illegal(nm_illegal), .ex_aluop(nm_aluop), .ex_rd(nm_rd), .ex_hold(nm_hold),
        .if_id_stall(nm_stall), .if_flush_req(nm_flush)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int tests = 0;
    int fails = 0;

    // Bundle layout: {valid,jalr,jal,branch,memread,memtoreg,memwrite,alusrc,regwrite,muldiv,illegal,aluop[1:0],rd[4:0]}
    logic [17:0] m_ex;
    int          m_rem;

    typedef struct {
        logic [6:0]  op;
        logic        flush;
        logic [17:0] exp;
    } vec_t;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic logic [17:0] act_bundle();
        return {ex_valid, ex_jalr, ex_jal, ex_branch, ex_memread, ex_memtoreg, ex_memwrite,
                ex_alusrc, ex_regwrite, ex_muldiv, ex_illegal, ex_aluop, ex_rd};
    endfunction

    // Reference decode: {jalr,jal,branch,memread,memtoreg,memwrite,alusrc,regwrite} + aluop
    function automatic logic [17:0] mdec(input logic [6:0] op, input logic [6:0] f7, input logic [4:0] rd);
        logic [7:0] f;
        logic [1:0] a;
        logic       md;
        md = 1'b0;
        case (op)
            7'h33: begin f = 8'b00000001; a = 2'b00; md = (f7 == 7'h01); end
            7'h13: begin f = 8'b00000011; a = 2'b01; end
            7'h03: begin f = 8'b00011011; a = 2'b10; end
            7'h23: begin f = 8'b00000110; a = 2'b10; end
            7'h63: begin f = 8'b00100000; a = 2'b00; end
            7'h6f: begin f = 8'b01000001; a = 2'b11; end
            7'h67: begin f = 8'b10000011; a = 2'b11; end
            default: return {1'b1, 8'b0, 1'b0, 1'b1, 2'b00, 5'd0};
        endcase
        return {1'b1, f, md, 1'b0, a, rd};
    endfunction

    function automatic bit m_hazard();
        bit u1, u2;
        logic [4:0] rd;
        rd = m_ex[4:0];
        u1 = (id_opcode != 7'h6f);
        u2 = (id_opcode == 7'h33) || (id_opcode == 7'h23) || (id_opcode == 7'h63);
        return id_valid && m_ex[17] && m_ex[13] && (rd != 0) &&
               ((u1 && rd == id_rs1) || (u2 && rd == id_rs2));
    endfunction

    task automatic set_in(input logic v, input logic [6:0] op, input logic [2:0] f3, input logic [6:0] f7,
                          input logic [4:0] rs1, input logic [4:0] rs2, input logic [4:0] rd);
        id_valid = v; id_opcode = op; id_funct3 = f3; id_funct7 = f7;
        id_rs1 = rs1; id_rs2 = rs2; id_rd = rd;
    endtask

    task automatic sample();
        bit hz, busy, exp_stall, exp_flush;
        @(negedge clk);
        hz   = m_hazard();
        busy = (m_rem > 0);
        exp_stall = dcache_stall || (!ex_redirect && (busy || hz));
        exp_flush = !dcache_stall && !ex_redirect && !busy && !hz && id_valid &&
                    (id_opcode == 7'h6f || id_opcode == 7'h67);
        chk("ex_bundle", 32'(act_bundle()), 32'(m_ex));
        chk("ex_hold", 32'(ex_hold), 32'(busy));
        chk("if_id_stall", 32'(if_id_stall), 32'(exp_stall));
        chk("if_flush_req", 32'(if_flush_req), 32'(exp_flush));
    endtask

    task automatic advance();
        bit hz;
        hz = m_hazard();
        if (!dcache_stall) begin
            if (ex_redirect) begin
                m_ex = '0; m_rem = 0;
            end else if (m_rem > 0) begin
                m_rem--;
            end else if (hz || !id_valid) begin
                m_ex = '0;
            end else begin
                m_ex  = mdec(id_opcode, id_funct7, id_rd);
                m_rem = m_ex[8] ? ((id_funct3[2] ? DIV_LAT : MUL_LAT) - 1) : 0;
            end
        end
        @(posedge clk);
        #1;
    endtask

    vec_t tbl[8];
    int   n_md, n_hold, n_stall;
    logic [2:0] hold_pat;
    logic [6:0] ops[9];

    initial begin
        tbl[0] = '{7'h33, 1'b0, 18'b1_0_0_0_0_0_0_0_1_0_0_00_00111};
        tbl[1] = '{7'h13, 1'b0, 18'b1_0_0_0_0_0_0_1_1_0_0_01_00111};
        tbl[2] = '{7'h03, 1'b0, 18'b1_0_0_0_1_1_0_1_1_0_0_10_00111};
        tbl[3] = '{7'h23, 1'b0, 18'b1_0_0_0_0_0_1_1_0_0_0_10_00111};
        tbl[4] = '{7'h63, 1'b0, 18'b1_0_0_1_0_0_0_0_0_0_0_00_00111};
        tbl[5] = '{7'h6f, 1'b1, 18'b1_0_1_0_0_0_0_0_1_0_0_11_00111};
        tbl[6] = '{7'h67, 1'b1, 18'b1_1_0_0_0_0_0_1_1_0_0_11_00111};
        tbl[7] = '{7'h37, 1'b0, 18'b1_0_0_0_0_0_0_0_0_0_1_00_00000};

        rst_n = 1'b0; dcache_stall = 1'b0; ex_redirect = 1'b0;
        set_in(1'b0, 7'h0, 3'h0, 7'h0, 5'd0, 5'd0, 5'd0);
        m_ex = '0; m_rem = 0;
        #2;
        chk("reset_bundle", 32'(act_bundle()), 32'd0);
        chk("reset_hold", 32'(ex_hold), 32'd0);
        chk("reset_stall", 32'(if_id_stall), 32'd0);
        #6 rst_n = 1'b1;
        @(posedge clk); #1;

        for (int i = 0; i < 8; i++) begin
            set_in(1'b1, tbl[i].op, 3'h0, 7'h00, 5'd1, 5'd2, 5'd7);
            sample();
            chk("tbl_flush", 32'(if_flush_req), 32'(tbl[i].flush));
            advance();
            id_valid = 1'b0;
            sample();
            chk("tbl_bundle", 32'(act_bundle()), 32'(tbl[i].exp));
            advance();
        end

        // Load-use: LOAD x5 then ADD using x5
        set_in(1'b1, 7'h03, 3'h2, 7'h00, 5'd1, 5'd0, 5'd5); sample(); advance();
        set_in(1'b1, 7'h33, 3'h0, 7'h00, 5'd5, 5'd2, 5'd6); sample();
        chk("lu_stall", 32'(if_id_stall), 32'd1); advance();
        sample();
        chk("lu_bubble", 32'(ex_valid), 32'd0);
        chk("lu_stall_once", 32'(if_id_stall), 32'd0); advance();
        sample();
        chk("lu_dep_rd", 32'({ex_valid, ex_rd}), 32'({1'b1, 5'd6})); advance();
        set_in(1'b1, 7'h03, 3'h2, 7'h00, 5'd1, 5'd0, 5'd0); sample(); advance();
        set_in(1'b1, 7'h33, 3'h0, 7'h00, 5'd0, 5'd0, 5'd6); sample();
        chk("lu_rd0_nostall", 32'(if_id_stall), 32'd0); advance();

        // MUL occupancy, plus the EN_MULDIV=0 instance seeing the same encoding
        set_in(1'b1, 7'h33, 3'h0, 7'h01, 5'd1, 5'd2, 5'd4); sample(); advance();
        chk("nm_illegal", 32'({nm_illegal, nm_muldiv}), 32'({1'b1, 1'b0}));
        set_in(1'b1, 7'h33, 3'h0, 7'h00, 5'd1, 5'd2, 5'd8);
        n_md = 0; n_hold = 0; n_stall = 0; hold_pat = '0;
        for (int i = 0; i < 5; i++) begin
            sample();
            if (i == 0) chk("nm_nostall", 32'(nm_stall), 32'd0);
            if (i < 3) hold_pat[2-i] = ex_hold;
            n_md += int'(ex_muldiv); n_hold += int'(ex_hold); n_stall += int'(if_id_stall);
            advance();
        end
        chk("mul_occupancy", n_md, 3);
        chk("mul_hold_pat", 32'(hold_pat), 32'b110);
        chk("mul_stalls", n_stall, 2);

        // DIV occupancy
        set_in(1'b1, 7'h33, 3'h4, 7'h01, 5'd1, 5'd2, 5'd9); sample(); advance();
        set_in(1'b1, 7'h33, 3'h0, 7'h00, 5'd1, 5'd2, 5'd8);
        n_md = 0; n_stall = 0;
        for (int i = 0; i < 40; i++) begin
            sample();
            n_md += int'(ex_muldiv); n_stall += int'(if_id_stall);
            advance();
        end
        chk("div_occupancy", n_md, 32);
        chk("div_stalls", n_stall, 31);

        // DIV frozen 4 cycles once cnt reaches 10
        set_in(1'b1, 7'h33, 3'h5, 7'h01, 5'd1, 5'd2, 5'd9); sample(); advance();
        set_in(1'b1, 7'h33, 3'h0, 7'h00, 5'd1, 5'd2, 5'd8);
        n_md = 0;
        for (int i = 0; i < 45; i++) begin
            dcache_stall = (i >= 21 && i < 25);
            sample();
            n_md += int'(ex_muldiv);
            advance();
        end
        dcache_stall = 1'b0;
        chk("div_frozen_occupancy", n_md, 36);

        // JAL flush, JAL under redirect, hazard under redirect
        set_in(1'b1, 7'h6f, 3'h0, 7'h00, 5'd0, 5'd0, 5'd1); sample();
        chk("jal_flush", 32'(if_flush_req), 32'd1); advance();
        ex_redirect = 1'b1; sample();
        chk("jal_redirect_noflush", 32'(if_flush_req), 32'd0); advance();
        ex_redirect = 1'b0; id_valid = 1'b0; sample();
        chk("redirect_bubble", 32'(ex_valid), 32'd0); advance();
        set_in(1'b1, 7'h03, 3'h2, 7'h00, 5'd1, 5'd0, 5'd5); sample(); advance();
        set_in(1'b1, 7'h33, 3'h0, 7'h00, 5'd5, 5'd2, 5'd6); ex_redirect = 1'b1; sample();
        chk("hz_redirect_nostall", 32'(if_id_stall), 32'd0); advance();
        ex_redirect = 1'b0; id_valid = 1'b0; sample();
        chk("hz_redirect_squash", 32'(ex_valid), 32'd0); advance();

        // Asynchronous reset in the middle of a DIV
        set_in(1'b1, 7'h33, 3'h4, 7'h01, 5'd1, 5'd2, 5'd9); sample(); advance();
        id_valid = 1'b0;
        for (int i = 0; i < 5; i++) begin sample(); advance(); end
        #2 rst_n = 1'b0;
        #1;
        chk("async_rst_bundle", 32'(act_bundle()), 32'd0);
        chk("async_rst_hold", 32'({ex_hold, if_id_stall}), 32'd0);
        m_ex = '0; m_rem = 0;
        @(negedge clk) rst_n = 1'b1;
        @(posedge clk); #1;

        // Randomized traffic against the reference model
        ops = '{7'h33, 7'h13, 7'h03, 7'h23, 7'h63, 7'h6f, 7'h67, 7'h37, 7'h33};
        for (int i = 0; i < 800; i++) begin
            logic [6:0] op, f7;
            op = ($urandom_range(0, 15) == 0) ? 7'($urandom) : ops[$urandom_range(0, 8)];
            case ($urandom_range(0, 2))
                0: f7 = 7'h00;
                1: f7 = 7'h20;
                default: f7 = 7'h01;
            endcase
            set_in(($urandom_range(0, 7) != 0), op, 3'($urandom), f7,
                   5'($urandom_range(0, 3)), 5'($urandom_range(0, 3)), 5'($urandom_range(0, 3)));
            dcache_stall = ($urandom_range(0, 7) == 0);
            ex_redirect  = ($urandom_range(0, 9) == 0);
            sample();
            advance();
        end

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
